// File: rtl/pre_pkg.sv
// Shared constants and types for the RGB-to-luma preprocessing path.
// Pixel layout, luma weight defaults and the output stream word shape live here.
package pre_pkg;

    localparam int PIX_W  = 8;
    localparam int RGB_W  = 3 * PIX_W;
    localparam int R_LSB  = 16;
    localparam int G_LSB  = 8;
    localparam int B_LSB  = 0;

    localparam int COEF_R_DEF = 77;
    localparam int COEF_G_DEF = 150;
    localparam int COEF_B_DEF = 29;

    localparam int AXIS_W = 32;
    localparam int BLK    = 8;
    localparam int POOL_W = BLK / 2;

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } row_par_t;

    typedef struct packed {
        logic              last;
        logic [AXIS_W-1:0] data;
    } axis_word_t;

    function automatic logic [PIX_W-1:0] rgb_chan(input logic [RGB_W-1:0] px, input int lsb);
        return px[lsb +: PIX_W];
    endfunction

endpackage

// File: rtl/rgb_to_luma.sv
// Combinational RGB888 to 8-bit luma with Q0.8 weights and round-half-up.
// Weights must sum to 256 so full white maps to 255 without overflow.
module rgb_to_luma
    import pre_pkg::*;
#(
    parameter int COEF_R = COEF_R_DEF,
    parameter int COEF_G = COEF_G_DEF,
    parameter int COEF_B = COEF_B_DEF
) (
    input  logic [RGB_W-1:0] i_rgb,
    output logic [PIX_W-1:0] o_y
);

    localparam logic [15:0] C_R = 16'(COEF_R);
    localparam logic [15:0] C_G = 16'(COEF_G);
    localparam logic [15:0] C_B = 16'(COEF_B);

    function automatic logic [PIX_W-1:0] round_q8(input logic [15:0] acc);
        logic [15:0] t;
        t = acc + 16'd128;
        return t[15:8];
    endfunction

    logic [15:0] w_acc;

    assign w_acc = C_R * {8'd0, rgb_chan(i_rgb, R_LSB)}
                 + C_G * {8'd0, rgb_chan(i_rgb, G_LSB)}
                 + C_B * {8'd0, rgb_chan(i_rgb, B_LSB)};

    assign o_y = round_q8(w_acc);

endmodule

// File: rtl/luma_pool_2x2.sv
// Converts 8-pixel RGB rows to luma and 2x2 average-pools each 8x8 block to 4x4,
// streaming one 32-bit word per row pair through an AXI-Stream output FIFO.
module luma_pool_2x2
    import pre_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int COEF_R     = COEF_R_DEF,
    parameter int COEF_G     = COEF_G_DEF,
    parameter int COEF_B     = COEF_B_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [RGB_W-1:0]  in_data1,
    input  logic [RGB_W-1:0]  in_data2,
    input  logic [RGB_W-1:0]  in_data3,
    input  logic [RGB_W-1:0]  in_data4,
    input  logic [RGB_W-1:0]  in_data5,
    input  logic [RGB_W-1:0]  in_data6,
    input  logic [RGB_W-1:0]  in_data7,
    input  logic [RGB_W-1:0]  in_data8,
    input  logic              in_valid,
    output logic [AXIS_W-1:0] m_axis_data,
    output logic              m_axis_valid,
    input  logic              m_axis_ready,
    output logic              m_axis_last,
    output logic              o_intr,
    output logic              o_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    function automatic logic [PIX_W-1:0] pool_round(input logic [9:0] part, input logic [8:0] sum);
        logic [9:0] t;
        t = part + {1'b0, sum} + 10'd2;
        return t[9:2];
    endfunction

    logic [RGB_W-1:0] w_pix [BLK];
    logic [PIX_W-1:0] w_y   [BLK];

    assign w_pix[0] = in_data1;
    assign w_pix[1] = in_data2;
    assign w_pix[2] = in_data3;
    assign w_pix[3] = in_data4;
    assign w_pix[4] = in_data5;
    assign w_pix[5] = in_data6;
    assign w_pix[6] = in_data7;
    assign w_pix[7] = in_data8;

    for (genvar k = 0; k < BLK; k++) begin : g_luma
        rgb_to_luma #(
            .COEF_R (COEF_R),
            .COEF_G (COEF_G),
            .COEF_B (COEF_B)
        ) u_luma (
            .i_rgb (w_pix[k]),
            .o_y   (w_y[k])
        );
    end

    // ---- stage 1: luma registered with row parity ----
    logic [PIX_W-1:0] r_y_p1 [BLK];
    logic             r_vld_p1;
    row_par_t         r_par_p1;
    logic [2:0]       r_row_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_p1  <= 1'b0;
            r_par_p1  <= ROW_EVEN;
            r_row_cnt <= 3'd0;
        end else begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_par_p1  <= row_par_t'(r_row_cnt[0]);
                r_row_cnt <= r_row_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (in_valid) begin
            for (int k = 0; k < BLK; k++) begin
                r_y_p1[k] <= w_y[k];
            end
        end
    end

    // ---- stage 2: horizontal pair sums, vertical accumulate, pooled word ----
    logic [8:0]        w_sum  [POOL_W];
    logic [9:0]        r_part [POOL_W];
    logic [AXIS_W-1:0] r_word_p2;
    logic              r_last_p2;
    logic              r_vld_p2;
    logic [1:0]        r_word_cnt;
    logic              w_even_p1;
    logic              w_odd_p1;

    for (genvar j = 0; j < POOL_W; j++) begin : g_sum
        assign w_sum[j] = {1'b0, r_y_p1[2*j]} + {1'b0, r_y_p1[2*j+1]};
    end

    assign w_even_p1 = r_vld_p1 && (r_par_p1 == ROW_EVEN);
    assign w_odd_p1  = r_vld_p1 && (r_par_p1 == ROW_ODD);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_p2   <= 1'b0;
            r_word_cnt <= 2'd0;
            for (int j = 0; j < POOL_W; j++) begin
                r_part[j] <= 10'd0;
            end
        end else begin
            r_vld_p2 <= w_odd_p1;
            if (w_even_p1) begin
                for (int j = 0; j < POOL_W; j++) begin
                    r_part[j] <= {1'b0, w_sum[j]};
                end
            end
            if (w_odd_p1) begin
                r_word_cnt <= r_word_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_odd_p1) begin
            for (int j = 0; j < POOL_W; j++) begin
                r_word_p2[j*PIX_W +: PIX_W] <= pool_round(r_part[j], w_sum[j]);
            end
            r_last_p2 <= (r_word_cnt == 2'd3);
        end
    end

    // ---- stage 3: output FIFO; a full FIFO still takes a push when it pops in the same cycle ----
    axis_word_t       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_intr;
    axis_word_t       w_head;
    axis_word_t       w_wr_word;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    assign w_head    = r_mem[r_rd_ptr];
    assign w_wr_word = '{last: r_last_p2, data: r_word_p2};
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop     = m_axis_valid && m_axis_ready;
    assign w_push    = r_vld_p2 && (!w_full || w_pop);
    assign w_drop    = r_vld_p2 && w_full && !w_pop;

    assign m_axis_valid = (r_count != '0);
    assign m_axis_data  = m_axis_valid ? w_head.data : '0;
    assign m_axis_last  = m_axis_valid && w_head.last;
    assign o_intr       = r_intr;
    assign o_overflow   = r_overflow;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_intr     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_intr <= w_pop && w_head.last;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_word;
        end
    end

endmodule

// File: tb/tb_luma_pool_2x2.sv
// Bench for luma_pool_2x2: directed and random rows against a block-level pooling model
// that predicts every output cycle, including FIFO hold, drop and interrupt timing.
module tb_luma_pool_2x2;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } word_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        ready;
    logic [23:0] px [8];
    logic [31:0] m_axis_data;
    logic        m_axis_valid;
    logic        m_axis_last;
    logic        o_intr;
    logic        o_overflow;

    int  checks   = 0;
    int  failures = 0;
    bit  tmo      = 1'b0;
    bit  rand_ready = 1'b0;

    word_t       q [$];
    logic [23:0] blk [8][8];
    int          rowcnt   = 0;
    bit          s0v      = 1'b0;
    bit          s1v      = 1'b0;
    word_t       s0;
    word_t       s1;
    bit          exp_intr = 1'b0;
    bit          exp_ovf  = 1'b0;

    luma_pool_2x2 #(.FIFO_DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .in_data1     (px[0]),
        .in_data2     (px[1]),
        .in_data3     (px[2]),
        .in_data4     (px[3]),
        .in_data5     (px[4]),
        .in_data6     (px[5]),
        .in_data7     (px[6]),
        .in_data8     (px[7]),
        .in_valid     (in_valid),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (ready),
        .m_axis_last  (m_axis_last),
        .o_intr       (o_intr),
        .o_overflow   (o_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int luma(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        return (77 * r + 150 * g + 29 * b + 128) / 256;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model steps at each falling edge: compare current outputs, then predict the next rising edge.
    always @(negedge clk) begin
        bit    pop;
        bit    nxt_intr;
        int    sz;
        int    sum;
        word_t w;
        chk("valid", 64'(m_axis_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("data", 64'(m_axis_data), 64'(q[0].data));
            chk("last", 64'(m_axis_last), 64'(q[0].last));
        end
        chk("intr", 64'(o_intr), 64'(exp_intr));
        chk("overflow", 64'(o_overflow), 64'(exp_ovf));
        chk("timeout", 64'(tmo), 64'(0));
        if (rst) begin
            q.delete();
            rowcnt   = 0;
            s0v      = 1'b0;
            s1v      = 1'b0;
            exp_intr = 1'b0;
            exp_ovf  = 1'b0;
        end else begin
            sz  = q.size();
            pop = (sz != 0) && ready;
            nxt_intr = 1'b0;
            if (pop) begin
                nxt_intr = q[0].last;
                void'(q.pop_front());
            end
            if (s0v) begin
                if (sz < DEPTH || pop) q.push_back(s0);
                else exp_ovf = 1'b1;
            end
            s0v = s1v;
            s0  = s1;
            s1v = 1'b0;
            if (in_valid) begin
                for (int c = 0; c < 8; c++) blk[rowcnt][c] = px[c];
                if (rowcnt % 2 == 1) begin
                    for (int j = 0; j < 4; j++) begin
                        sum = luma(blk[rowcnt-1][2*j]) + luma(blk[rowcnt-1][2*j+1])
                            + luma(blk[rowcnt][2*j])   + luma(blk[rowcnt][2*j+1]);
                        w.data[8*j +: 8] = 8'((sum + 2) / 4);
                    end
                    w.last = (rowcnt == 7);
                    s1  = w;
                    s1v = 1'b1;
                end
                rowcnt = (rowcnt + 1) % 8;
            end
            exp_intr = nxt_intr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_row(input logic [23:0] ev, input logic [23:0] od, input bit rnd, input int r);
        for (int c = 0; c < 8; c++) px[c] = rnd ? 24'($urandom) : ((r % 2 == 1) ? od : ev);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [23:0] ev, input logic [23:0] od, input bit rnd, input bit gaps);
        for (int r = 0; r < 8; r++) begin
            drive_row(ev, od, rnd, r);
            if (gaps) repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        rand_ready = 1'b0;
        ready = 1'b1;
        while ((q.size() != 0 || s0v || s1v) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) tmo = 1'b1;
        repeat (3) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        ready    = 1'b1;
        for (int c = 0; c < 8; c++) px[c] = 24'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // reset mid-stream discards a partial block
        for (int r = 0; r < 3; r++) drive_row(24'd0, 24'd0, 1'b1, r);
        do_reset(2);
        repeat (2) step();

        // constant-colour blocks
        send_block(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0);
        drain();
        send_block(24'hFF0000, 24'hFF0000, 1'b0, 1'b0);
        send_block(24'h00FF00, 24'h00FF00, 1'b0, 1'b0);
        send_block(24'h000000, 24'hFFFFFF, 1'b0, 1'b0);
        drain();

        // random pixels, random sink readiness, gappy and full-rate input
        rand_ready = 1'b1;
        repeat (6) send_block(24'd0, 24'd0, 1'b1, 1'b1);
        repeat (3) send_block(24'd0, 24'd0, 1'b1, 1'b0);
        drain();

        // stalled sink: third block dropped, overflow sticky, then drain in order
        do_reset(1);
        ready = 1'b0;
        repeat (3) send_block(24'd0, 24'd0, 1'b1, 1'b0);
        repeat (4) step();
        drain();

        // full FIFO with a pop coinciding with the push of the next word
        do_reset(1);
        ready = 1'b0;
        repeat (2) send_block(24'd0, 24'd0, 1'b1, 1'b0);
        for (int r = 0; r < 8; r++) drive_row(24'd0, 24'd0, 1'b1, r);
        step();
        ready = 1'b1;
        step();
        ready = 1'b0;
        repeat (3) step();
        drain();

        // reset after four rows, then a full block realigns
        for (int r = 0; r < 4; r++) drive_row(24'd0, 24'd0, 1'b1, r);
        do_reset(1);
        send_block(24'd0, 24'd0, 1'b1, 1'b0);
        drain();

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
